// File: rtl/xor4_parity_arb_pkg.sv
// rtl/xor4_parity_arb_pkg.sv - shared constants and FSM encoding for xor4_parity_arb
//
// Purpose: single home for the controller state encoding, the requester
// count and the nibble width used by the parity arbiter and its XOR4 cell.
package xor4_parity_arb_pkg;

  localparam int NUM_REQ = 4;  // requesters served by the arbiter
  localparam int NIB_W   = 4;  // bits consumed per CALC cycle

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/xor4_parity_arb_xor4.sv
// rtl/xor4_parity_arb_xor4.sv - four-input XOR equation cell
//
// Purpose: the one shared parity reduction element of the datapath; the
// top feeds it one nibble per cycle.
// Ports:
//   nib_i  in  4  nibble to reduce
//   par_o  out 1  XOR of the four nibble bits
module xor4_parity_arb_xor4
  import xor4_parity_arb_pkg::*;
(
  input  logic [NIB_W-1:0] nib_i,
  output logic             par_o
);

  assign par_o = nib_i[0] ^ nib_i[1] ^ nib_i[2] ^ nib_i[3];

endmodule

// File: rtl/xor4_parity_arb.sv
// rtl/xor4_parity_arb.sv - round-robin arbiter computing serial word parity
//
// Purpose: grants one of four requesters, captures its word and folds it
// nibble by nibble through a single XOR4 cell, then reports the parity,
// the requester index and a one-cycle ack.
// Ports:
//   i_clk     in  1          clock, rising edge
//   i_rst_n   in  1          asynchronous active-low reset
//   i_req     in  4          level requests, bit k = requester k
//   i_data    in  4*WORD_W   requester k word at [k*WORD_W +: WORD_W]
//   o_gnt     out 4          one-hot grant, grant edge through DONE
//   o_ack     out 4          one-hot ack pulse in DONE
//   o_valid   out 1          result valid pulse in DONE
//   o_parity  out 1          XOR of all bits of the granted word
//   o_id      out 2          granted requester index
//   o_busy    out 1          high in CALC and DONE
module xor4_parity_arb
  import xor4_parity_arb_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [NUM_REQ-1:0]      i_req,
  input  logic [NUM_REQ*WORD_W-1:0] i_data,
  output logic [NUM_REQ-1:0]      o_gnt,
  output logic [NUM_REQ-1:0]      o_ack,
  output logic                    o_valid,
  output logic                    o_parity,
  output logic [1:0]              o_id,
  output logic                    o_busy
);

  localparam int NIB   = WORD_W / NIB_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_e               state_q, state_d;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [1:0]           id_q, id_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [WORD_W-1:0]    shift_q, shift_d;
  logic                 acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic                 xor4_out;
  logic                 pick_vld;
  logic [1:0]           pick_idx;
  logic [1:0]           cand;

  xor4_parity_arb_xor4 u_xor4 (
    .nib_i (shift_q[NIB_W-1:0]),
    .par_o (xor4_out)
  );

  // Round-robin search. Walking offsets from the far end down to 0 lets the
  // closest asserted request to rr_ptr overwrite any farther one.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = rr_ptr_q;
    cand     = rr_ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      cand = rr_ptr_q + 2'(i);
      if (i_req[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    gnt_d    = gnt_q;
    shift_d  = shift_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          state_d = ST_CALC;
          id_d    = pick_idx;
          gnt_d   = NUM_REQ'(1) << pick_idx;
          shift_d = i_data[int'(pick_idx) * WORD_W +: WORD_W];
          acc_d   = 1'b0;
          cnt_d   = '0;
        end
      end
      ST_CALC: begin
        acc_d   = acc_q ^ xor4_out;
        shift_d = shift_q >> NIB_W;
        cnt_d   = cnt_q + CNT_W'(1);
        // Last nibble is being folded this cycle.
        if (cnt_q == CNT_W'(NIB - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        rr_ptr_d = id_q + 2'd1;
        gnt_d    = '0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= 2'd0;
      id_q     <= 2'd0;
      gnt_q    <= '0;
      shift_q  <= '0;
      acc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      gnt_q    <= gnt_d;
      shift_q  <= shift_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them
  // without waiting for an edge.
  assign o_gnt    = gnt_q;
  assign o_valid  = (state_q == ST_DONE);
  assign o_ack    = (state_q == ST_DONE) ? gnt_q : '0;
  assign o_parity = (state_q == ST_DONE) & acc_q;
  assign o_id     = (state_q == ST_DONE) ? id_q : 2'd0;
  assign o_busy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xor4_parity_arb.sv
// tb/tb_xor4_parity_arb.sv - directed self-checking bench for xor4_parity_arb
module tb_xor4_parity_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [3:0]  req = '0;
  logic [63:0] data = '0;
  logic [3:0]  gnt, ack;
  logic        valid, parity, busy;
  logic [1:0]  id;

  logic [3:0]  req8 = '0;
  logic [31:0] data8 = '0;
  logic [3:0]  gnt8, ack8;
  logic        valid8, parity8, busy8;
  logic [1:0]  id8;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  xor4_parity_arb #(.WORD_W(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data),
    .o_gnt(gnt), .o_ack(ack), .o_valid(valid), .o_parity(parity),
    .o_id(id), .o_busy(busy)
  );

  xor4_parity_arb #(.WORD_W(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req8), .i_data(data8),
    .o_gnt(gnt8), .o_ack(ack8), .o_valid(valid8), .o_parity(parity8),
    .o_id(id8), .o_busy(busy8)
  );

  task automatic test_reset();
    rst_n = 1'b0;
    req = '0;
    req8 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({gnt, ack, valid, parity, id, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {gnt, ack, valid, parity, id, busy});
    end
    n_checks++;
    if ({gnt8, ack8, valid8, parity8, id8, busy8} !== 13'd0) begin
      n_fail++;
      $display("FAIL reset_outputs_w8: got %b expected 0", {gnt8, ack8, valid8, parity8, id8, busy8});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_no_req_busy: got %b expected 0", busy);
    end
  endtask

  // Single transactions: capture, valid on the 5th cycle after capture.
  task automatic test_parity_table();
    logic [3:0]  reqs [4];
    logic [15:0] words [4];
    logic        pars [4];
    int          ids [4];
    reqs[0] = 4'b0001; words[0] = 16'h0001; pars[0] = 1'b1; ids[0] = 0;
    reqs[1] = 4'b0100; words[1] = 16'hFFFF; pars[1] = 1'b0; ids[1] = 2;
    reqs[2] = 4'b0100; words[2] = 16'h8421; pars[2] = 1'b0; ids[2] = 2;
    reqs[3] = 4'b0100; words[3] = 16'h8420; pars[3] = 1'b1; ids[3] = 2;
    for (int e = 0; e < 4; e++) begin
      @(negedge clk);
      req = reqs[e];
      data = '0;
      data[ids[e]*16 +: 16] = words[e];
      @(posedge clk);
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);
        if (k == 1) begin
          req = '0;
          n_checks++;
          if (gnt !== reqs[e] || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL tbl%0d_grant: gnt=%b busy=%b expected gnt=%b busy=1", e, gnt, busy, reqs[e]);
          end
        end
        if (k < 5) begin
          n_checks++;
          if (valid !== 1'b0 || ack !== 4'b0 || parity !== 1'b0 || id !== 2'd0) begin
            n_fail++;
            $display("FAIL tbl%0d_early_k%0d: valid=%b ack=%b par=%b id=%0d expected all 0", e, k, valid, ack, parity, id);
          end
        end
        if (k == 5) begin
          n_checks++;
          if (valid !== 1'b1 || parity !== pars[e] || id !== 2'(ids[e]) || ack !== reqs[e]) begin
            n_fail++;
            $display("FAIL tbl%0d_result: valid=%b par=%b id=%0d ack=%b expected 1 %b %0d %b",
                     e, valid, parity, id, ack, pars[e], ids[e], reqs[e]);
          end
        end
        if (k == 6) begin
          n_checks++;
          if (valid !== 1'b0 || ack !== 4'b0 || busy !== 1'b0 || gnt !== 4'b0) begin
            n_fail++;
            $display("FAIL tbl%0d_after: valid=%b ack=%b busy=%b gnt=%b expected 0", e, valid, ack, busy, gnt);
          end
        end
      end
    end
  endtask

  // All four requesting: ids 0,1,2,3,0 with valid every 6 cycles.
  task automatic test_round_robin();
    int  npulse = 0;
    bit  drained = 0;
    logic exp_par [4];
    exp_par[0] = 1'b1; exp_par[1] = 1'b0; exp_par[2] = 1'b1; exp_par[3] = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    data = {16'h000F, 16'h0007, 16'h0003, 16'h0001};
    req = 4'b1111;
    @(posedge clk);
    for (int c = 1; c <= 31; c++) begin
      @(negedge clk);
      n_checks++;
      if (busy ? !$onehot(gnt) : (gnt !== 4'b0)) begin
        n_fail++;
        $display("FAIL rr_gnt_c%0d: gnt=%b busy=%b expected one-hot while busy", c, gnt, busy);
      end
      if (valid === 1'b1) begin
        n_checks++;
        if (c !== 5 + 6 * npulse || id !== 2'(npulse % 4) || parity !== exp_par[npulse % 4]) begin
          n_fail++;
          $display("FAIL rr_pulse%0d: cycle=%0d id=%0d par=%b expected cycle=%0d id=%0d par=%b",
                   npulse, c, id, parity, 5 + 6 * npulse, npulse % 4, exp_par[npulse % 4]);
        end
        npulse++;
      end
    end
    req = '0;
    n_checks++;
    if (npulse !== 5) begin
      n_fail++;
      $display("FAIL rr_pulse_count: got %0d expected 5", npulse);
    end
    for (int c = 0; c < 12 && !drained; c++) begin
      @(negedge clk);
      if (busy === 1'b0) drained = 1;
    end
    n_checks++;
    if (!drained) begin
      n_fail++;
      $display("FAIL rr_drain: busy=%b expected 0 within 12 cycles", busy);
    end
  endtask

  // Requester 1 drops its request and its data changes mid-CALC.
  task automatic test_drop_request();
    @(negedge clk);
    req = 4'b0010;
    data = '0;
    data[31:16] = 16'h0010;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 2) begin
        req = '0;
        data = '0;
      end
      if (k == 5) begin
        n_checks++;
        if (valid !== 1'b1 || id !== 2'd1 || ack !== 4'b0010 || parity !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_result: valid=%b id=%0d ack=%b par=%b expected 1 1 0010 1", valid, id, ack, parity);
        end
      end
      if (k == 6) begin
        n_checks++;
        if (valid !== 1'b0 || busy !== 1'b0) begin
          n_fail++;
          $display("FAIL drop_after: valid=%b busy=%b expected 0 0", valid, busy);
        end
      end
    end
  endtask

  // Serve id 2, then reset mid-CALC; the next 1111 round must start at id 0.
  task automatic test_reset_mid();
    bit seen = 0;
    @(negedge clk);
    req = 4'b0100;
    data = '0;
    data[47:32] = 16'h0001;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) req = '0;
      if (k == 5) begin
        n_checks++;
        if (valid !== 1'b1 || id !== 2'd2) begin
          n_fail++;
          $display("FAIL rstmid_pre: valid=%b id=%0d expected 1 2", valid, id);
        end
      end
    end
    req = 4'b0100;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL rstmid_calc: busy=%b gnt=%b expected 1 0100", busy, gnt);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({gnt, ack, valid, parity, id, busy} !== 13'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: got %b expected 0", {gnt, ack, valid, parity, id, busy});
    end
    @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (valid !== 1'b0 || ack !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_held: valid=%b ack=%b busy=%b expected 0", valid, ack, busy);
    end
    rst_n = 1'b1;
    req = 4'b1111;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) req = '0;
      if (valid === 1'b1 && !seen) begin
        seen = 1;
        n_checks++;
        if (id !== 2'd0 || ack !== 4'b0001 || c !== 5) begin
          n_fail++;
          $display("FAIL rstmid_first: id=%0d ack=%b cycle=%0d expected 0 0001 5", id, ack, c);
        end
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL rstmid_no_valid: valid never seen, expected pulse at cycle 5");
    end
  endtask

  // 8-bit instance: two CALC cycles, valid on the 3rd cycle after capture.
  task automatic test_word8();
    @(negedge clk);
    req8 = 4'b1000;
    data8 = {8'h07, 24'h0};
    @(posedge clk);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) req8 = '0;
      if (k < 3) begin
        n_checks++;
        if (valid8 !== 1'b0 || busy8 !== 1'b1) begin
          n_fail++;
          $display("FAIL w8_early_k%0d: valid=%b busy=%b expected 0 1", k, valid8, busy8);
        end
      end
      if (k == 3) begin
        n_checks++;
        if (valid8 !== 1'b1 || parity8 !== 1'b1 || id8 !== 2'd3 || ack8 !== 4'b1000) begin
          n_fail++;
          $display("FAIL w8_result: valid=%b par=%b id=%0d ack=%b expected 1 1 3 1000", valid8, parity8, id8, ack8);
        end
      end
      if (k == 4) begin
        n_checks++;
        if (valid8 !== 1'b0 || busy8 !== 1'b0) begin
          n_fail++;
          $display("FAIL w8_after: valid=%b busy=%b expected 0 0", valid8, busy8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_parity_table();
    test_round_robin();
    test_drop_request();
    test_reset_mid();
    test_word8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/xor4_parity_arb.md
XOR4_PARITY_ARB -- requirements
Module: xor4_parity_arb

Interface
REQ-001 Parameter: WORD_W, default 16, requester word width in bits; SHALL be a multiple of 4 and >= 4; NIB = WORD_W/4.
REQ-002 Clocking SHALL be one clock with an asynchronous, active-low reset.
REQ-003 Port: i_clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: i_rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: i_req  in  4  per-requester request, level, bit k = requester k.
REQ-006 Port: i_data  in  4*WORD_W  requester k word at [k*WORD_W +: WORD_W]; sampled only at grant.
REQ-007 Port: o_gnt  out  4  one-hot grant, held from grant edge through DONE.
REQ-008 Port: o_ack  out  4  one-hot, single-cycle pulse in DONE for granted requester.
REQ-009 Port: o_valid  out  1  single-cycle pulse in DONE; o_parity/o_id valid only then.
REQ-010 Port: o_parity  out  1  XOR of all WORD_W bits of the granted word (even-parity bit).
REQ-011 Port: o_id  out  2  index of granted requester.
REQ-012 Port: o_busy  out  1  high in CALC and DONE.

Function
REQ-013 FSM states SHALL be IDLE, CALC, DONE.
REQ-014 IDLE: if any i_req bit is high, the block SHALL grant at that edge, capture the selected word into a WORD_W shift register, clear the accumulator, clear the nibble counter, and enter CALC; otherwise remain in IDLE.
REQ-015 Arbitration SHALL be round-robin: search starts at pointer rr_ptr, then rr_ptr+1 ... wrapping mod 4; the first asserted request wins.
REQ-016 CALC: each cycle, the low nibble of the shift register SHALL feed the single shared XOR4 unit; acc <= acc ^ xor4_out; shift right by 4; counter++.
REQ-017 CALC SHALL last exactly NIB cycles, then enter DONE.
REQ-018 DONE: o_valid=1, o_ack[id]=1, o_parity=acc, o_id=id, all for exactly one cycle; rr_ptr <= id+1 (mod 4); next state IDLE.
REQ-019 Latency: capture edge to o_valid high SHALL be NIB+1 cycles; back-to-back grants SHALL be spaced NIB+2 cycles apart.
REQ-020 A requester dropping i_req after grant SHALL NOT abort; the result and ack SHALL still be delivered.
REQ-021 Requests and i_data changes during CALC/DONE SHALL be ignored until IDLE.
REQ-022 Outside DONE, o_valid, o_ack, o_parity and o_id SHALL be 0.
REQ-023 Only one XOR4 instance SHALL exist; there SHALL be no parallel reduction.

Reset
REQ-024 On i_rst_n low: state=IDLE, rr_ptr=0, acc=0, counter=0, shift register=0, all outputs 0, immediately and without waiting for a clock edge.
REQ-025 Reset asserted mid-CALC or in DONE SHALL discard the operation; no ack SHALL be issued.
REQ-026 After reset release, the first grant SHALL use rr_ptr=0.

Structure
REQ-027 A shared header SHALL hold the FSM state encodings, the requester count (4) and the nibble width (4).
REQ-028 The only sub-module SHALL be the XOR4 equation cell, instantiated once as the datapath; arbiter, FSM and accumulator SHALL stay in xor4_parity_arb.

Verification
REQ-029 i_req=0001, word0=16'h0001 -> o_valid 5 cycles after capture, o_parity=1, o_id=0, o_ack=0001.
REQ-030 i_req=0100, word2=16'hFFFF -> o_parity=0, o_id=2, o_ack=0100; word2=16'h8421 -> o_parity=0; word2=16'h8420 -> o_parity=1.
REQ-031 i_req=1111 held -> o_id sequence 0,1,2,3,0, o_valid pulses 6 cycles apart, o_gnt always one-hot.
REQ-032 i_req=0010 then dropped to 0 in CALC cycle 2 -> ack and o_valid for id 1 still occur on schedule.
REQ-033 i_rst_n pulsed low in CALC cycle 2 (after id 2 served earlier) -> outputs 0 asynchronously, no ack; with i_req=1111 after release, first o_id=0.
REQ-034 WORD_W=8, word3=8'h07 -> o_valid 3 cycles after capture, o_parity=1, o_id=3.
